// File: rtl/button_gesture_if.sv
// Button gesture bus: debounced level in, one-cycle gesture event pulses out.
interface button_gesture_if;
  logic pressed;
  logic click_pulse;
  logic double_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic busy;

  modport master (
    output pressed,
    input  click_pulse, double_pulse, long_pulse, repeat_pulse, busy
  );

  modport slave (
    input  pressed,
    output click_pulse, double_pulse, long_pulse, repeat_pulse, busy
  );
endinterface

// File: rtl/button_gesture_decoder.sv
// Classifies a debounced button level into click / double / long / repeat pulses.
// Optional auto-repeat while held is enabled by defining GESTURE_REPEAT_EN.
module button_gesture_decoder #(
  parameter int unsigned CLK_HZ           = 16_000_000,
  parameter int unsigned Simulacion       = 0,
  parameter int unsigned LONG_MS          = 800,
  parameter int unsigned DOUBLE_MS        = 300,
  parameter int unsigned REPEAT_MS        = 150,
  parameter int unsigned LONG_TICKS_SIM   = 8,
  parameter int unsigned DOUBLE_TICKS_SIM = 4,
  parameter int unsigned REPEAT_TICKS_SIM = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  button_gesture_if.slave   bus
);

  localparam int unsigned TICKS_PER_MS = CLK_HZ / 1000;
  localparam int unsigned LONG_TICKS   = (Simulacion != 0) ? LONG_TICKS_SIM   : TICKS_PER_MS * LONG_MS;
  localparam int unsigned DOUBLE_TICKS = (Simulacion != 0) ? DOUBLE_TICKS_SIM : TICKS_PER_MS * DOUBLE_MS;
  localparam int unsigned REPEAT_TICKS = (Simulacion != 0) ? REPEAT_TICKS_SIM : TICKS_PER_MS * REPEAT_MS;
  localparam int unsigned MAX_LD       = (LONG_TICKS > DOUBLE_TICKS) ? LONG_TICKS : DOUBLE_TICKS;
  localparam int unsigned MAX_TICKS    = (MAX_LD > REPEAT_TICKS) ? MAX_LD : REPEAT_TICKS;
  localparam int unsigned TIMER_W      = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_WAIT2  = 3'd2,
    S_PRESS2 = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [TIMER_W-1:0]   r_timer, w_timer_nxt;
  logic                 r_p_q;
  logic                 r_click, r_double, r_long, r_repeat, r_busy;
  logic                 w_click, w_double, w_long, w_repeat, w_reload;
  logic                 w_rise, w_fall;

  assign w_rise = bus.pressed & ~r_p_q;
  assign w_fall = ~bus.pressed & r_p_q;

  // State, timer, input history and registered event outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_p_q    <= 1'b0;
      r_click  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_p_q    <= bus.pressed;
      r_click  <= w_click;
      r_double <= w_double;
      r_long   <= w_long;
      r_repeat <= w_repeat;
      r_busy   <= (w_state_nxt != S_IDLE);
    end
  end

  // Edges take priority over timer limits in every state
  always_comb begin
    w_state_nxt = r_state;
    w_click     = 1'b0;
    w_double    = 1'b0;
    w_long      = 1'b0;
    w_repeat    = 1'b0;
    w_reload    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) w_state_nxt = S_PRESS1;
      end
      S_PRESS1: begin
        if (w_fall) begin
          w_state_nxt = S_WAIT2;
        end else if (bus.pressed && r_timer == TIMER_W'(LONG_TICKS - 1)) begin
          w_long      = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_WAIT2: begin
        if (w_rise) begin
          w_state_nxt = S_PRESS2;
        end else if (r_timer == TIMER_W'(DOUBLE_TICKS - 1)) begin
          w_click     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_PRESS2: begin
        if (w_fall) begin
          w_double    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (w_fall) begin
          w_state_nxt = S_IDLE;
        end
`ifdef GESTURE_REPEAT_EN
        else if (r_timer == TIMER_W'(REPEAT_TICKS - 1)) begin
          w_repeat = 1'b1;
          w_reload = 1'b1;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Timer restarts on any state change or repeat; saturates while parked
    if (w_state_nxt != r_state || w_reload) begin
      w_timer_nxt = '0;
    end else if (r_timer != {TIMER_W{1'b1}}) begin
      w_timer_nxt = r_timer + TIMER_W'(1);
    end else begin
      w_timer_nxt = r_timer;
    end
  end

  assign bus.click_pulse  = r_click;
  assign bus.double_pulse = r_double;
  assign bus.long_pulse   = r_long;
  assign bus.repeat_pulse = r_repeat;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Randomized + directed bench for button_gesture_decoder against a deadline-based gesture model.
module tb_button_gesture_decoder;

  localparam int L = 8;
  localparam int D = 4;
  localparam int R = 2;
`ifdef GESTURE_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  button_gesture_if bus();

  button_gesture_decoder #(.Simulacion(1)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: gesture phase plus absolute-cycle deadlines
  int         cyc      = 0;
  int         phase    = 0;   // 0 idle, 1 first press, 2 gap, 3 second press, 4 held
  int         deadline = 0;
  logic       p_prev   = 1'b0;
  logic [3:0] exp_pulse = '0; // {click, double, long, repeat}
  logic       exp_busy  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  task automatic model_step(input logic p);
    logic rise, fall;
    rise = p & ~p_prev;
    fall = ~p & p_prev;
    cyc++;
    exp_pulse = '0;
    case (phase)
      0: if (rise) begin phase = 1; deadline = cyc + L; end
      1: begin
        if (fall) begin
          phase = 2; deadline = cyc + D;
        end else if (cyc == deadline) begin
          exp_pulse[1] = 1'b1; phase = 4; deadline = cyc + R;
        end
      end
      2: begin
        if (rise) phase = 3;
        else if (cyc == deadline) begin exp_pulse[3] = 1'b1; phase = 0; end
      end
      3: if (fall) begin exp_pulse[2] = 1'b1; phase = 0; end
      4: begin
        if (fall) phase = 0;
        else if (REP_EN && cyc == deadline) begin exp_pulse[0] = 1'b1; deadline = cyc + R; end
      end
      default: phase = 0;
    endcase
    p_prev   = p;
    exp_busy = (phase != 0);
  endtask

  task automatic step(input logic p);
    @(negedge clk);
    bus.pressed = p;
    @(posedge clk);
    model_step(p);
    #1;
    check_eq("pulses", 32'({bus.click_pulse, bus.double_pulse, bus.long_pulse, bus.repeat_pulse}),
             32'(exp_pulse));
    check_eq("busy", 32'(bus.busy), 32'(exp_busy));
  endtask

  task automatic hold(input logic p, input int n);
    for (int i = 0; i < n; i++) step(p);
  endtask

  task automatic apply_reset(input logic p);
    @(negedge clk);
    bus.pressed = p;
    reset_n     = 1'b0;
    #1;
    check_eq("rst_async", 32'({bus.click_pulse, bus.double_pulse, bus.long_pulse,
                               bus.repeat_pulse, bus.busy}), 32'(0));
    phase = 0; p_prev = 1'b0; exp_pulse = '0; exp_busy = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_held", 32'({bus.click_pulse, bus.double_pulse, bus.long_pulse,
                              bus.repeat_pulse, bus.busy}), 32'(0));
    reset_n = 1'b1;
  endtask

  initial begin
    bus.pressed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_vals", 32'({bus.click_pulse, bus.double_pulse, bus.long_pulse,
                                bus.repeat_pulse, bus.busy}), 32'(0));
    #1 reset_n = 1'b1;

    hold(0, 3);
    hold(1, 3); hold(0, 10);                           // single click
    hold(1, 3); hold(0, 2); hold(1, 3); hold(0, 8);    // double click
    hold(1, 20); hold(0, 6);                           // long + repeat
    hold(1, L); hold(0, 8);                            // fall on long limit
    hold(1, L + 1); hold(0, 4);                        // just long
    hold(1, 3); hold(0, D); hold(1, 2); hold(0, 6);    // rise on gap limit
    hold(1, 3); hold(0, D + 1); hold(1, 2); hold(0, 8);
    hold(1, 3); hold(0, 2); apply_reset(1'b0); hold(0, 10);  // reset in gap
    hold(1, 4); apply_reset(1'b1); hold(1, 12); hold(0, 3);  // reset while held

    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 24) == 0) apply_reset(1'($urandom_range(0, 1)));
      hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
    end
    hold(0, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
